// File: rtl/program_loader_pkg.sv
// Shared constants and loader state encoding for the instruction-memory program loader.
package program_loader_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BYTE_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_MEM_DEPTH  = 1024;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs accepted stream bytes little-endian into one instruction word; word_full flags the
// byte that completes the word, and word_next already contains that byte.
module program_loader_word_assembler
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
)(
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [DATA_WIDTH-1:0] word_next,
    output logic                  word_full
);

    localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int CNT_W = $clog2(LANES);

    logic [CNT_W-1:0]                  byte_cnt;
    logic [LANES-1:0][BYTE_WIDTH-1:0]  lanes;
    logic [LANES-1:0][BYTE_WIDTH-1:0]  lanes_nxt;

    always_comb begin
        lanes_nxt = lanes;
        if (byte_en) begin
            lanes_nxt[byte_cnt] = byte_in;
        end
    end

    assign word_next = lanes_nxt;
    assign word_full = byte_en && (byte_cnt == CNT_W'(LANES - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            byte_cnt <= '0;
            lanes    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (byte_en) begin
            lanes    <= lanes_nxt;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Host byte-stream loader: writes a length-prefixed image into instruction memory and holds
// the core until done. Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN0    | accept word-count low byte
// LEN1    | accept word-count high byte, range check
// DATA    | accept data bytes into the word assembler
// WRITE   | one-cycle instruction-memory write strobe
// CSUM    | accept and compare checksum byte
// DONE    | image complete, core released
// ERR     | load aborted, core held
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
)(
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam int LANES      = DATA_WIDTH / BYTE_WIDTH;
    localparam int LEN_W      = LEN_BYTES * BYTE_WIDTH;
    localparam int WORD_SHIFT = $clog2(LANES);
    localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(MEM_DEPTH / LANES);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam loader_state_e IMAGE_END = S_CSUM;
`else
    localparam loader_state_e IMAGE_END = S_DONE;
`endif

    loader_state_e         state, state_nxt;
    logic [BYTE_WIDTH-1:0] len_lo;
    logic [LEN_W-1:0]      len_value, word_count, word_index;
    logic                  load_start, data_accept, word_full, last_word;
    logic [DATA_WIDTH-1:0] word_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] csum;
`endif

    assign byte_ready  = state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
    assign data_accept = byte_valid && byte_ready && (state == S_DATA);
    assign len_value   = {byte_in, len_lo};
    assign last_word   = (word_index + 1'b1) == word_count;
    assign load_start  = start && (state inside {S_IDLE, S_DONE, S_ERR});

    program_loader_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_word_assembler (
        .clk       (clk),
        .arst      (arst),
        .clear     (load_start),
        .byte_en   (data_accept),
        .byte_in   (byte_in),
        .word_next (word_next),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE:  if (load_start) state_nxt = S_LEN0;
            S_LEN0:  if (byte_valid) state_nxt = S_LEN1;
            S_LEN1: begin
                if (byte_valid) begin
                    if (len_value == '0)            state_nxt = IMAGE_END;
                    else if (len_value > MAX_WORDS) state_nxt = S_ERR;
                    else                            state_nxt = S_DATA;
                end
            end
            S_DATA:  if (word_full) state_nxt = S_WRITE;
            S_WRITE: begin
                wr_en     = 1'b1;
                state_nxt = last_word ? IMAGE_END : S_DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM:  if (byte_valid) state_nxt = (byte_in == csum) ? S_DONE : S_ERR;
`endif
            S_DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
                if (load_start) state_nxt = S_LEN0;
            end
            S_ERR: begin
                error = 1'b1;
                if (load_start) state_nxt = S_LEN0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address/data are captured with the completing byte so they are stable throughout WRITE
    // and keep their last value afterwards.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            len_lo     <= '0;
            word_count <= '0;
            word_index <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            if (load_start) word_index <= '0;
            else if (state == S_WRITE) word_index <= word_index + 1'b1;
            if (state == S_LEN0 && byte_valid) len_lo <= byte_in;
            if (state == S_LEN1 && byte_valid) word_count <= len_value;
            if (word_full) begin
                wr_addr <= ADDR_WIDTH'(word_index) << WORD_SHIFT;
                wr_data <= word_next;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            csum <= '0;
        end else if (load_start) begin
            csum <= '0;
        end else if (data_accept) begin
            csum <= csum ^ byte_in;
        end
    end
`endif

endmodule
